// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : forward_ctrl
// Purpose  : Operand-forwarding and load-use hazard controller for the
//            5-stage pipeline. Tracks the producers in EX and MEM, registers
//            the select lines of the two 4-way EX operand muxes, and raises a
//            one-cycle stall when ID reads the destination of a load in EX.
// Ports    : clk_i          pipeline clock (rising edge)
//            rst_i          asynchronous active-low reset
//            hold_i         global freeze; no internal state changes
//            flush_i        branch taken; instruction leaving ID becomes bubble
//            id_valid_i     ID holds a real instruction
//            id_rs1_i/rs2_i source register indices in ID
//            id_use_rs1_i/rs2_i  source read enables
//            id_rd_i        destination index in ID
//            id_regwrite_i  instruction writes rd
//            id_memread_i   instruction is a load
//            fwd_a_o/b_o    operand mux selects for the instruction in EX
//                           (00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result)
//            stall_o        combinational load-use stall request
//            stall_cnt_o    saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0]       c_SEL_RF  = 2'b00;
    localparam logic [1:0]       c_SEL_MEM = 2'b01;
    localparam logic [1:0]       c_SEL_EX  = 2'b10;
    localparam logic [REG_W-1:0] c_REG_X0  = '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Producer records. The WB stage is not kept: the register file is
    // write-through, so a WB producer is already visible through select 00
    // and its record would never influence any output.
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_regwrite;
    logic             r_ex_memread;
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_regwrite;

    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_match_rs1;
    logic w_ex_match_rs2;
    logic w_mem_match_rs1;
    logic w_mem_match_rs2;
    logic w_stall;
    logic w_bubble;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // A source never matches x0 or an unused operand, so those always read
    // the register file and never trigger a stall.
    assign w_ex_match_rs1  = r_ex_valid & r_ex_regwrite & (r_ex_rd == id_rs1_i)
                           & (id_rs1_i != c_REG_X0) & id_use_rs1_i;
    assign w_ex_match_rs2  = r_ex_valid & r_ex_regwrite & (r_ex_rd == id_rs2_i)
                           & (id_rs2_i != c_REG_X0) & id_use_rs2_i;
    assign w_mem_match_rs1 = r_mem_valid & r_mem_regwrite & (r_mem_rd == id_rs1_i)
                           & (id_rs1_i != c_REG_X0) & id_use_rs1_i;
    assign w_mem_match_rs2 = r_mem_valid & r_mem_regwrite & (r_mem_rd == id_rs2_i)
                           & (id_rs2_i != c_REG_X0) & id_use_rs2_i;

    // A load in EX has no result yet; the dependent instruction waits one
    // cycle, after which the load sits in MEM and is forwarded from there.
    assign w_stall  = id_valid_i & r_ex_valid & r_ex_memread
                    & (w_ex_match_rs1 | w_ex_match_rs2);

    assign w_bubble = w_stall | flush_i | ~id_valid_i;

    // The youngest producer (EX) wins over the older one (MEM).
    assign w_sel_a  = w_ex_match_rs1  ? c_SEL_EX  :
                      w_mem_match_rs1 ? c_SEL_MEM : c_SEL_RF;
    assign w_sel_b  = w_ex_match_rs2  ? c_SEL_EX  :
                      w_mem_match_rs2 ? c_SEL_MEM : c_SEL_RF;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_fwd_a        <= c_SEL_RF;
            r_fwd_b        <= c_SEL_RF;
            r_stall_cnt    <= '0;
        end else if (!hold_i) begin
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;

            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_fwd_a       <= c_SEL_RF;
                r_fwd_b       <= c_SEL_RF;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_rd       <= id_rd_i;
                r_ex_regwrite <= id_regwrite_i;
                r_ex_memread  <= id_memread_i;
                r_fwd_a       <= w_sel_a;
                r_fwd_b       <= w_sel_b;
            end

            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign fwd_a_o     = r_fwd_a;
    assign fwd_b_o     = r_fwd_b;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
